// File: rtl/sdr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_arb_pkg
//  Description : Shared types and helpers for the SDRAM channel arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================

package sdr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } arb_state_t;

    // Returned on a timed-out read; sliced down to the data width by users.
    localparam logic [63:0] c_err_data = '1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdr_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_rr_pick
//  Description : Combinational round-robin picker; first eligible index after
//                the previous grant, wrapping modulo NREQ.
//  Revision    : 1.0 - initial release
// ============================================================================

module sdr_rr_pick
    import sdr_arb_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_last_grant,
    output logic            o_valid,
    output logic [IW-1:0]   o_winner
);

    logic [IW:0] w_idx;

    // Scan from the farthest candidate down so the nearest one after
    // last_grant overwrites all others and ends up as the winner.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = {1'b0, i_last_grant} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NREQ)) begin
                w_idx = w_idx - (IW+1)'(NREQ);
            end
            if (i_elig[w_idx[IW-1:0]]) begin
                o_valid  = 1'b1;
                o_winner = w_idx[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdr_chan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_chan_arbiter
//  Description : Round-robin sharing of one SDRAM controller channel among
//                NREQ level-request requesters, with requester-0 lock.
//  Revision    : 1.0 - initial release
// ============================================================================

module sdr_chan_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rnw,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_din,
    input  logic [NREQ*2-1:0] req_be,
    output logic [NREQ*DW-1:0] req_dout,
    output logic [NREQ-1:0]   req_rdy,
    output logic [AW-1:0]     ch_addr,
    output logic [DW-1:0]     ch_din,
    output logic [1:0]        ch_be,
    output logic              ch_rnw,
    output logic              ch_req,
    input  logic [DW-1:0]     ch_dout,
    input  logic              ch_ready,
    output logic              busy,
    output logic              err
);

    localparam int c_iw = idx_width(NREQ);
    localparam int c_cw = idx_width(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [c_iw-1:0]   r_last_grant;
    logic [c_iw-1:0]   w_winner;
    logic              w_valid;
    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   r_rdy;
    logic [DW-1:0]     r_dout [NREQ];
    logic [AW-1:0]     r_ch_addr;
    logic [DW-1:0]     r_ch_din;
    logic [1:0]        r_ch_be;
    logic              r_ch_rnw;
    logic              r_ch_req;
    logic              r_err;
    logic [c_cw-1:0]   r_cnt;
    logic              w_issue;
    logic              w_ack;
    logic              w_timeout;

    assign w_elig = req & (lock ? {{(NREQ-1){1'b0}}, 1'b1} : {NREQ{1'b1}});

    sdr_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_elig       (w_elig),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (ch_ready == r_ch_req) begin
                    w_ack        = 1'b1;
                    w_state_next = DONE;
                end else if (r_cnt == c_cw'(TIMEOUT)) begin
                    w_timeout    = 1'b1;
                    w_state_next = FLUSH;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            FLUSH: begin
                // Late acknowledge is swallowed here; no rdy is generated.
                if (ch_ready == r_ch_req) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdy        <= '0;
            r_err        <= 1'b0;
            r_ch_addr    <= '0;
            r_ch_din     <= '0;
            r_ch_be      <= '0;
            r_ch_rnw     <= 1'b1;
            // Matching parity leaves the controller seeing no pending request.
            r_ch_req     <= ch_ready;
            r_last_grant <= c_iw'(NREQ - 1);
            r_cnt        <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_dout[i] <= '0;
            end
        end else begin
            r_rdy <= '0;
            if (w_issue) begin
                r_ch_addr    <= req_addr[w_winner*AW +: AW];
                r_ch_din     <= req_din[w_winner*DW +: DW];
                r_ch_be      <= req_be[w_winner*2 +: 2];
                r_ch_rnw     <= req_rnw[w_winner];
                r_ch_req     <= ~r_ch_req;
                r_last_grant <= w_winner;
                r_cnt        <= '0;
            end
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + c_cw'(1);
            end
            if (w_ack) begin
                if (r_ch_rnw) begin
                    r_dout[r_last_grant] <= ch_dout;
                end
                r_rdy[r_last_grant] <= 1'b1;
            end
            if (w_timeout) begin
                r_err                <= 1'b1;
                r_dout[r_last_grant] <= c_err_data[DW-1:0];
                r_rdy[r_last_grant]  <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_dout
            assign req_dout[g*DW +: DW] = r_dout[g];
        end
    endgenerate

    assign req_rdy = r_rdy;
    assign ch_addr = r_ch_addr;
    assign ch_din  = r_ch_din;
    assign ch_be   = r_ch_be;
    assign ch_rnw  = r_ch_rnw;
    assign ch_req  = r_ch_req;
    assign busy    = (r_state != IDLE);
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sdr_chan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdr_chan_arbiter
//  Description : Self-checking bench for sdr_chan_arbiter with a toggle-
//                handshake channel model and a completion scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_sdr_chan_arbiter;

    localparam int NREQ    = 3;
    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                lock;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_rnw;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_din;
    logic [NREQ*2-1:0]   req_be;
    logic [NREQ*DW-1:0]  req_dout;
    logic [NREQ-1:0]     req_rdy;
    logic [AW-1:0]       ch_addr;
    logic [DW-1:0]       ch_din;
    logic [1:0]          ch_be;
    logic                ch_rnw;
    logic                ch_req;
    logic [DW-1:0]       ch_dout  = '0;
    logic                ch_ready = 1'b1;
    logic                busy;
    logic                err;

    always #5 clk = ~clk;

    sdr_chan_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .lock     (lock),
        .req      (req),
        .req_rnw  (req_rnw),
        .req_addr (req_addr),
        .req_din  (req_din),
        .req_be   (req_be),
        .req_dout (req_dout),
        .req_rdy  (req_rdy),
        .ch_addr  (ch_addr),
        .ch_din   (ch_din),
        .ch_be    (ch_be),
        .ch_rnw   (ch_rnw),
        .ch_req   (ch_req),
        .ch_dout  (ch_dout),
        .ch_ready (ch_ready),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        int             idx;
        logic           rnw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  din;
        logic [1:0]     be;
        logic [DW-1:0]  exp_dout;
    } vec_t;

    typedef struct {
        int             idx;
        logic [DW-1:0]  data;
        logic           err;
    } exp_t;

    exp_t           sb_q[$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             m_delay  = 5;
    int             m_cnt    = 0;
    logic [DW-1:0]  exp_slot [NREQ];

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hACDB;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] data, input logic e);
        exp_t x;
        x.idx  = idx;
        x.data = data;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    task automatic issue(input int idx, input logic rnw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] be);
        req_rnw[idx]          = rnw;
        req_addr[idx*AW +: AW] = a;
        req_din[idx*DW +: DW]  = d;
        req_be[idx*2 +: 2]     = be;
        req[idx]               = 1'b1;
    endtask

    task automatic wait_rdy(input int idx, input int budget, output int cyc);
        logic ok;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (req_rdy[idx]) ok = 1'b1;
        end
        check($sformatf("wait_rdy%0d", idx), {31'b0, ok}, 32'd1);
    endtask

    // Channel model: acknowledges m_delay cycles after a parity mismatch.
    always @(negedge clk) begin
        if (reset) begin
            m_cnt = 0;
        end else if (ch_req != ch_ready) begin
            m_cnt++;
            if (m_cnt >= m_delay) begin
                ch_dout  = rd_word(ch_addr);
                ch_ready = ch_req;
                m_cnt    = 0;
            end
        end else begin
            m_cnt = 0;
        end
    end

    // Scoreboard: every rdy pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (req_rdy != '0) begin
            check("rdy_onehot", {31'b0, $onehot(req_rdy)}, 32'd1);
            if (sb_q.size() == 0) begin
                check("rdy_unexpected", {29'b0, req_rdy}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rdy_idx", {29'b0, req_rdy}, 32'(1) << e.idx);
                check("rdy_dout", {16'b0, req_dout[e.idx*DW +: DW]}, {16'b0, e.data});
                check("rdy_err", {31'b0, err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        logic old;
        int   cyc;
        int   lg;
        int   cnt;

        vecs[0] = '{1, 1'b1, 24'h001234, 16'h0000, 2'b11, 16'hBEEF};
        vecs[1] = '{0, 1'b0, 24'h000010, 16'h00A5, 2'b01, 16'h0000};
        vecs[2] = '{2, 1'b1, 24'hABCDEF, 16'h0000, 2'b11, 16'h6134};
        vecs[3] = '{2, 1'b0, 24'h000002, 16'h1111, 2'b11, 16'h6134};
        vecs[4] = '{0, 1'b1, 24'h100000, 16'h0000, 2'b11, 16'hACDB};
        vecs[5] = '{1, 1'b0, 24'h000003, 16'h2222, 2'b10, 16'hBEEF};

        reset = 1'b1; lock = 1'b0; req = '0; req_rnw = '0;
        req_addr = '0; req_din = '0; req_be = '0;
        for (int i = 0; i < NREQ; i++) exp_slot[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_rdy", {29'b0, req_rdy}, 32'd0);
        check("rst_dout", {16'b0, req_dout[47:32]} | {16'b0, req_dout[31:16]} | {16'b0, req_dout[15:0]}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ch_addr", {8'b0, ch_addr}, 32'd0);
        check("rst_ch_din", {16'b0, ch_din}, 32'd0);
        check("rst_ch_be", {30'b0, ch_be}, 32'd0);
        check("rst_ch_rnw", {31'b0, ch_rnw}, 32'd1);
        check("rst_ch_req", {31'b0, ch_req}, {31'b0, ch_ready});
        reset = 1'b0;

        // Table-driven single transactions.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            old = ch_req;
            issue(vecs[v].idx, vecs[v].rnw, vecs[v].addr, vecs[v].din, vecs[v].be);
            push_exp(vecs[v].idx, vecs[v].exp_dout, 1'b0);
            @(negedge clk);
            check("issue_toggle", {31'b0, ch_req}, {31'b0, !old});
            check("issue_addr", {8'b0, ch_addr}, {8'b0, vecs[v].addr});
            check("issue_din", {16'b0, ch_din}, {16'b0, vecs[v].din});
            check("issue_be", {30'b0, ch_be}, {30'b0, vecs[v].be});
            check("issue_rnw", {31'b0, ch_rnw}, {31'b0, vecs[v].rnw});
            check("issue_busy", {31'b0, busy}, 32'd1);
            req_addr[vecs[v].idx*AW +: AW] = ~vecs[v].addr;
            req_din[vecs[v].idx*DW +: DW]  = ~vecs[v].din;
            wait_rdy(vecs[v].idx, 40, cyc);
            req[vecs[v].idx] = 1'b0;
            check("addr_stable", {8'b0, ch_addr}, {8'b0, vecs[v].addr});
            @(negedge clk);
            check("rdy_one_cycle", {29'b0, req_rdy}, 32'd0);
            exp_slot[vecs[v].idx] = vecs[v].exp_dout;
        end
        lg = 1;

        // Round-robin with all requesters held high.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            issue(i, 1'b1, 24'h000100 + AW'(i), 16'h0000, 2'b11);
        end
        for (int k = 0; k < 6; k++) begin
            int w;
            w = (lg + 1 + k) % NREQ;
            push_exp(w, rd_word(24'h000100 + AW'(w)), 1'b0);
            exp_slot[w] = rd_word(24'h000100 + AW'(w));
        end
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 6; c++) begin
            @(negedge clk);
            if (req_rdy != '0) begin
                cnt++;
                if (cnt == 6) req = '0;
            end
        end
        check("rr_grants", cnt, 32'd6);
        repeat (3) @(negedge clk);
        check("rr_idle", {31'b0, busy}, 32'd0);

        // Lock: requesters 1 and 2 must be ignored.
        lock = 1'b1;
        old  = ch_req;
        issue(1, 1'b1, 24'h000011, 16'h0000, 2'b11);
        issue(2, 1'b1, 24'h000022, 16'h0000, 2'b11);
        repeat (8) @(negedge clk);
        check("lock_no_issue", {31'b0, ch_req}, {31'b0, old});
        check("lock_idle", {31'b0, busy}, 32'd0);
        issue(0, 1'b0, 24'h000040, 16'h00A5, 2'b01);
        push_exp(0, exp_slot[0], 1'b0);
        @(negedge clk);
        check("lock_toggle", {31'b0, ch_req}, {31'b0, !old});
        check("lock_rnw", {31'b0, ch_rnw}, 32'd0);
        check("lock_be", {30'b0, ch_be}, 32'd1);
        check("lock_din", {16'b0, ch_din}, 32'h00A5);
        wait_rdy(0, 40, cyc);
        req[0] = 1'b0;
        @(negedge clk);
        req  = '0;
        lock = 1'b0;

        // Lock rising while requester 2 is in flight.
        @(negedge clk);
        issue(2, 1'b1, 24'h000222, 16'h0000, 2'b11);
        push_exp(2, rd_word(24'h000222), 1'b0);
        exp_slot[2] = rd_word(24'h000222);
        @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        lock = 1'b1;
        issue(1, 1'b1, 24'h000111, 16'h0000, 2'b11);
        wait_rdy(2, 40, cyc);
        req[2] = 1'b0;
        old = ch_req;
        repeat (6) @(negedge clk);
        check("mid_lock_hold", {31'b0, ch_req}, {31'b0, old});
        issue(0, 1'b1, 24'h000333, 16'h0000, 2'b11);
        push_exp(0, rd_word(24'h000333), 1'b0);
        exp_slot[0] = rd_word(24'h000333);
        @(negedge clk);
        check("mid_grant0", {31'b0, ch_req}, {31'b0, !old});
        wait_rdy(0, 40, cyc);
        req  = '0;
        @(negedge clk);
        lock = 1'b0;

        // Timeout with a late acknowledge.
        m_delay = 40;
        @(negedge clk);
        old = ch_req;
        issue(1, 1'b1, 24'h000555, 16'h0000, 2'b11);
        push_exp(1, 16'hFFFF, 1'b1);
        @(negedge clk);
        check("to_toggle", {31'b0, ch_req}, {31'b0, !old});
        wait_rdy(1, 60, cyc);
        req[1] = 1'b0;
        check("to_wait_cycles", cyc, 32'd16);
        check("to_err", {31'b0, err}, 32'd1);
        check("to_flush_busy", {31'b0, busy}, 32'd1);
        cnt = 0;
        while (ch_ready != ch_req && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("to_late_ack", {31'b0, ch_ready == ch_req}, 32'd1);
        repeat (3) @(negedge clk);
        check("to_back_idle", {31'b0, busy}, 32'd0);
        check("to_err_sticky", {31'b0, err}, 32'd1);
        check("to_slot", {16'b0, req_dout[DW +: DW]}, 32'h0000FFFF);

        // Reset while a transaction is waiting on the channel.
        @(negedge clk);
        issue(0, 1'b1, 24'h000777, 16'h0000, 2'b11);
        repeat (3) @(negedge clk);
        check("rw_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        check("rw_rdy", {29'b0, req_rdy}, 32'd0);
        check("rw_parity", {31'b0, ch_req}, {31'b0, ch_ready});
        check("rw_err", {31'b0, err}, 32'd0);
        check("rw_busy_clr", {31'b0, busy}, 32'd0);
        check("rw_dout", {16'b0, req_dout[DW +: DW]}, 32'd0);
        for (int i = 0; i < NREQ; i++) exp_slot[i] = '0;
        m_delay = 5;

        // After reset requester 0 wins first, then 2.
        @(negedge clk);
        issue(0, 1'b1, 24'h000888, 16'h0000, 2'b11);
        issue(2, 1'b1, 24'h000999, 16'h0000, 2'b11);
        push_exp(0, rd_word(24'h000888), 1'b0);
        push_exp(2, rd_word(24'h000999), 1'b0);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_rdy[i]) begin
                    req[i] = 1'b0;
                    cnt++;
                end
            end
        end
        check("post_rst_grants", cnt, 32'd2);

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
